// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the base byte-write-enable patterns that are shifted into the addressed lanes.
package mem_access_unit_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    RESP    = 2'b10
  } state_e;

  localparam logic [3:0] WEN_B = 4'b0001;
  localparam logic [3:0] WEN_H = 4'b0011;
  localparam logic [3:0] WEN_W = 4'b1111;

  // Size 11 behaves exactly like a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// Picks the addressed byte/halfword out of a 32-bit SRAM read word and
// sign- or zero-extends it; word accesses pass through unchanged.
module load_aligner
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane select and extension
  always_comb begin
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    if (is_word(size)) begin
      data = rdata;
    end else if (size == SIZE_H) begin
      data = {{16{sign & half_lane[15]}}, half_lane};
    end else begin
      data = {{24{sign & byte_lane[7]}}, byte_lane};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one request at a time to a synchronous data SRAM.
// Stores complete in the accept cycle; loads return a response two cycles later.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit          CHECK_ALIGN    = 1'b1,
  parameter logic [31:0] SRAM_ADDR_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_waddr,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_waddr,
  output logic        addr_error
);

  state_e      state_q, state_d;
  logic        accept;
  logic        misaligned;
  logic [1:0]  eff_off;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [4:0]  waddr_q;
  logic [31:0] ld_data;

  assign accept = req_valid & req_ready;

  // Alignment check; with checking disabled the low bits below the access
  // size are dropped so lane selection always lands on a natural boundary.
  always_comb begin
    misaligned = 1'b0;
    eff_off    = req_addr[1:0];
    if (is_word(req_size)) begin
      misaligned = |req_addr[1:0];
      eff_off    = '0;
    end else if (req_size == SIZE_H) begin
      misaligned = req_addr[0];
      eff_off    = {req_addr[1], 1'b0};
    end
    if (!CHECK_ALIGN) misaligned = 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !misaligned && !req_wr) state_d = RD_WAIT;
      RD_WAIT: state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request handshake and SRAM port drive
  always_comb begin
    req_ready       = (state_q == IDLE);
    data_sram_en    = 1'b0;
    data_sram_wen   = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    if (req_valid && req_ready && !misaligned) begin
      data_sram_en   = 1'b1;
      data_sram_addr = req_addr & SRAM_ADDR_MASK;
      if (req_wr) begin
        if (is_word(req_size)) begin
          data_sram_wen   = WEN_W;
          data_sram_wdata = req_wdata;
        end else if (req_size == SIZE_H) begin
          data_sram_wen   = WEN_H << eff_off;
          data_sram_wdata = {2{req_wdata[15:0]}};
        end else begin
          data_sram_wen   = WEN_B << eff_off;
          data_sram_wdata = {4{req_wdata[7:0]}};
        end
      end
    end
  end

  load_aligner u_load_aligner (
    .rdata  (data_sram_rdata),
    .offset (off_q),
    .size   (size_q),
    .sign   (sign_q),
    .data   (ld_data)
  );

  // Load context capture, response register and misalignment pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      off_q      <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      waddr_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_waddr <= '0;
      addr_error <= 1'b0;
    end else begin
      addr_error <= accept & misaligned;
      if (accept && !misaligned && !req_wr) begin
        off_q   <= eff_off;
        size_q  <= req_size;
        sign_q  <= req_sign;
        waddr_q <= req_waddr;
      end
      if (state_q == RD_WAIT) begin
        resp_valid <= 1'b1;
        resp_rdata <= ld_data;
        resp_waddr <= waddr_q;
      end else if (state_q == RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a word SRAM model answers the DUT, and a
// byte-addressed reference memory predicts store lanes and load results.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_waddr;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_waddr;
  logic        addr_error;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  refmem [0:1023];
  logic [31:0] sram   [0:255];

  always #5 clk = ~clk;

  mem_access_unit #(
    .CHECK_ALIGN    (1'b1),
    .SRAM_ADDR_MASK (32'hFFFF_FFFC)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_wr          (req_wr),
    .req_size        (req_size),
    .req_sign        (req_sign),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_waddr       (req_waddr),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_waddr      (resp_waddr),
    .addr_error      (addr_error)
  );

  // Synchronous SRAM, one-cycle read latency
  always @(posedge clk) begin
    if (data_sram_en) begin
      if (data_sram_wen == 4'b0000) begin
        data_sram_rdata <= sram[data_sram_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (data_sram_wen[b])
            sram[data_sram_addr[9:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Runs one request; entered and left 1 time unit after a rising edge.
  task automatic do_op(input bit wr, input logic [1:0] size, input bit sign,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] waddr, input int hold);
    int          n;
    int          base;
    bit          mis;
    logic [3:0]  ew;
    logic [31:0] exp_w;
    logic [31:0] exp_r;
    logic [31:0] held;
    n    = nbytes(size);
    base = int'(addr[9:0]);
    mis  = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
    req_valid = 1'b1; req_wr = wr; req_size = size; req_sign = sign;
    req_addr = addr;  req_wdata = wdata; req_waddr = waddr;
    #1;
    check_eq("req_ready_T", {31'b0, req_ready}, 32'd1);
    check_eq("sram_en_T", {31'b0, data_sram_en}, {31'b0, ~mis});
    if (!mis) begin
      ew = 4'b0000;
      if (wr) for (int i = 0; i < n; i++) ew[int'(addr[1:0]) + i] = 1'b1;
      check_eq("sram_addr", data_sram_addr, {addr[31:2], 2'b00});
      check_eq("sram_wen", {28'b0, data_sram_wen}, {28'b0, ew});
      if (wr) begin
        exp_w = (n == 1) ? {4{wdata[7:0]}} : (n == 2) ? {2{wdata[15:0]}} : wdata;
        check_eq("sram_wdata", data_sram_wdata, exp_w);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (mis) begin
      check_eq("addr_error_pulse", {31'b0, addr_error}, 32'd1);
      check_eq("mis_req_ready", {31'b0, req_ready}, 32'd1);
      check_eq("mis_resp_valid", {31'b0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      check_eq("addr_error_clear", {31'b0, addr_error}, 32'd0);
      return;
    end
    check_eq("addr_error_idle", {31'b0, addr_error}, 32'd0);
    if (wr) begin
      for (int i = 0; i < n; i++) refmem[base + i] = wdata[8*i +: 8];
      check_eq("st_no_resp", {31'b0, resp_valid}, 32'd0);
      check_eq("st_req_ready", {31'b0, req_ready}, 32'd1);
      return;
    end
    check_eq("ld_T1_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("ld_T1_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    exp_r = '0;
    for (int i = 0; i < n; i++) exp_r |= 32'(refmem[base + i]) << (8 * i);
    if (sign && n == 1 && exp_r[7])  exp_r |= 32'hFFFF_FF00;
    if (sign && n == 2 && exp_r[15]) exp_r |= 32'hFFFF_0000;
    check_eq("ld_T2_resp_valid", {31'b0, resp_valid}, 32'd1);
    check_eq("ld_rdata", resp_rdata, exp_r);
    check_eq("ld_waddr", {27'b0, resp_waddr}, {27'b0, waddr});
    held = resp_rdata;
    // A competing store held on the request port must be ignored while busy.
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0000;
    for (int c = 0; c < hold; c++) begin
      resp_ready = 1'b0;
      #1;
      check_eq("busy_req_ready", {31'b0, req_ready}, 32'd0);
      check_eq("busy_sram_en", {31'b0, data_sram_en}, 32'd0);
      @(posedge clk); #1;
      check_eq("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      check_eq("hold_rdata", resp_rdata, held);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check_eq("hs_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("hs_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      sram[i] = w;
      for (int b = 0; b < 4; b++) refmem[4*i + b] = w[8*b +: 8];
    end
    resetn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_sign = 1'b0;
    req_addr = '0; req_wdata = '0; req_waddr = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_resp_waddr", {27'b0, resp_waddr}, 32'd0);
    check_eq("rst_addr_error", {31'b0, addr_error}, 32'd0);
    check_eq("rst_sram_en", {31'b0, data_sram_en}, 32'd0);
    check_eq("rst_sram_wen", {28'b0, data_sram_wen}, 32'd0);
    check_eq("rst_sram_addr", data_sram_addr, 32'd0);
    check_eq("rst_sram_wdata", data_sram_wdata, 32'd0);
    check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;

    do_op(1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 0);
    do_op(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0000_00A5, 5'd0, 0);
    do_op(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd4, 0);
    do_op(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 5'd5, 1);
    do_op(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h8001_1234, 5'd0, 0);
    do_op(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 5'd9, 0);
    do_op(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 5'd9, 0);
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 5'd31, 3);
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 5'd1, 0);
    do_op(1'b0, 2'b01, 1'b1, 32'h0000_0201, 32'h0, 5'd2, 0);
    do_op(1'b1, 2'b11, 1'b0, 32'h0000_0101, 32'h1234_5678, 5'd0, 0);
    do_op(1'b1, 2'b01, 1'b0, 32'h0000_0206, 32'hCAFE_F00D, 5'd0, 0);
    do_op(1'b0, 2'b11, 1'b1, 32'h0000_0204, 32'h0, 5'd7, 0);

    // Reset while waiting on the SRAM read abandons the load.
    req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0200; req_waddr = 5'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    resetn    = 1'b0;
    #1;
    check_eq("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("midrst_sram_en", {31'b0, data_sram_en}, 32'd0);
    check_eq("midrst_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check_eq("postrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("postrst_req_ready", {31'b0, req_ready}, 32'd1);
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 5'd3, 0);

    for (int k = 0; k < 300; k++) begin
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 1023)), $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the core's execute stage and the synchronous data SRAM.
- Accepts one memory request at a time, drives the data_sram request port (en, byte-write enables, addr, wdata), and waits the SRAM's one-cycle read latency.
- Extracts and sign- or zero-extends the addressed byte, halfword or word.
- Returns a load response with its destination register to write-back.

Parameters:
- CHECK_ALIGN, 1, when 1, misaligned halfword/word requests are rejected with addr_error; when 0, the low address bits are ignored.
- SRAM_ADDR_MASK, 32'hFFFF_FFFC, mask applied to req_addr to form data_sram_addr (word addressed).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- req_sign  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_waddr  in  5  load destination register.
- data_sram_en  out  1  SRAM access enable.
- data_sram_wen  out  4  byte write enables; 0000 = read.
- data_sram_addr  out  32  SRAM address.
- data_sram_wdata  out  32  lane-replicated store data.
- data_sram_rdata  in  32  read data, valid the cycle after a read enable.
- resp_valid  out  1  load result available.
- resp_ready  in  1  write-back accepts the result.
- resp_rdata  out  32  aligned, extended load data.
- resp_waddr  out  5  destination register of the load.
- addr_error  out  1  one-cycle pulse on a rejected misaligned request.

Behaviour:
- States: IDLE, RD_WAIT, RESP. Reset enters IDLE asynchronously.
- Reset values: resp_valid 0, resp_rdata 0, resp_waddr 0, addr_error 0. All SRAM outputs are combinationally 0 in IDLE when req_valid=0.
- req_ready = 1 only in IDLE. A request is accepted in the cycle where req_valid and req_ready are both 1 (cycle T).
- Alignment:
  - A halfword is misaligned when addr[0]=1.
  - A word is misaligned when addr[1:0]≠00.
  - With CHECK_ALIGN=1, a misaligned request is accepted but issues no SRAM access (data_sram_en=0), raises addr_error in T+1 for one cycle, and the state stays IDLE.
- Store, aligned:
  - In cycle T, data_sram_en=1, addr = req_addr & SRAM_ADDR_MASK.
  - wen: byte = 0001<<addr[1:0]; halfword = 0011<<addr[1:0]; word = 1111.
  - wdata: byte replicated ×4; halfword replicated ×2; word as is.
  - No response. The state stays IDLE, so back-to-back stores run one per cycle.
- Load, aligned:
  - In cycle T, data_sram_en=1, wen=0000.
  - Register addr[1:0], size, sign and waddr, then go to RD_WAIT.
- RD_WAIT (T+1):
  - Select the byte lane rdata[8*a+7:8*a] or halfword lane rdata[16*a1+15:16*a1]. Extend per sign.
  - Register the result into resp_rdata/resp_waddr, set resp_valid, go to RESP.
  - resp_valid is therefore first high in cycle T+2. Load-to-response latency is 2 cycles.
- RESP:
  - resp_valid, resp_rdata and resp_waddr are held stable until resp_valid & resp_ready.
  - On the handshake, clear resp_valid and return to IDLE. A new request is accepted the following cycle, never in the same cycle.
- Simultaneous events:
  - req_valid in a non-IDLE state is ignored (req_ready=0). The requester holds the request.
- Reset mid-operation:
  - Asserting resetn=0 in RD_WAIT or RESP abandons the load: state goes to IDLE, resp_valid 0.
  - SRAM outputs go to 0 immediately.
- req_size=11 is handled exactly as 10.

Decomposition:
- Shared package holds:
  - Size encodings SIZE_B/SIZE_H/SIZE_W.
  - State encoding IDLE/RD_WAIT/RESP as a 2-bit localparam set.
  - The wen base patterns.
- One natural combinational sub-module, load_aligner (inputs rdata, offset, size, sign; output extended data), reused later for an LWL/LWR extension. Store lane/wen generation stays inline.

Test Plan:
- SW to 0x0000_0104, wdata 0xDEAD_BEEF -> cycle T: en=1, wen=1111, sram_addr 0x104, wdata 0xDEADBEEF; resp_valid never rises.
- SB to 0x0000_0103, wdata 0x0000_00A5 -> wen=1000, wdata 0xA5A5A5A5; LBU from 0x103 with rdata 0xA5xx_xxxx -> resp_rdata 0x0000_00A5 in T+2; LB -> 0xFFFF_FFA5.
- LH from 0x0000_0202, rdata 0x8001_1234 -> resp_rdata 0xFFFF_8001; LHU -> 0x0000_8001; resp_waddr equals req_waddr (e.g. 5'd9).
- LW with resp_ready=0 for 3 cycles -> resp_valid stays 1, data stable, req_ready=0; next request accepted one cycle after the handshake.
- LW to 0x0000_0102 (CHECK_ALIGN=1) -> data_sram_en=0, addr_error pulses 1 cycle, no resp_valid, req_ready stays 1.
- resetn low during RD_WAIT -> resp_valid 0, state IDLE, req_ready 1 after release; a following LW completes normally.
